// File: rtl/char_stream_writer.sv
// Character stream writer. It turns an ASCII byte stream into Avalon-MM writes to a
// COLS x ROWS character buffer. Optional backspace support is enabled by defining CSW_BACKSPACE_EN.
module char_stream_writer #(
  parameter int COLS   = 80,
  parameter int ROWS   = 60,
  parameter int X_BITS = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              clear_start,
  output logic              busy,
  output logic [X_BITS-1:0] cursor_x,
  output logic [5:0]        cursor_y,
  output logic [X_BITS+5:0] m_address,
  output logic              m_chipselect,
  output logic              m_write,
  output logic              m_byteenable,
  output logic [7:0]        m_writedata,
  input  logic              m_waitrequest
);

  // state   | meaning
  // S_IDLE  | waiting for a character or a clear request
  // S_WRITE | single character write on the bus, held until m_waitrequest low
  // S_CLEAR | blanking every screen position in row-major order
  typedef enum logic [1:0] {S_IDLE, S_WRITE, S_CLEAR} state_t;

  localparam int Y_BITS = 6;
  localparam int CW     = $clog2(COLS * ROWS);
  localparam logic [X_BITS-1:0] LAST_X   = X_BITS'(COLS - 1);
  localparam logic [Y_BITS-1:0] LAST_Y   = Y_BITS'(ROWS - 1);
  localparam logic [X_BITS-1:0] ONE_X    = X_BITS'(1);
  localparam logic [Y_BITS-1:0] ONE_Y    = Y_BITS'(1);
  localparam logic [CW-1:0]     CLR_LAST = CW'(COLS * ROWS - 1);
  localparam logic [CW-1:0]     ONE_C    = CW'(1);

  state_t                  r_state;
  logic [X_BITS-1:0]       r_cx;
  logic [Y_BITS-1:0]       r_cy;
  logic [X_BITS+Y_BITS-1:0] r_addr;
  logic [7:0]              r_data;
  logic                    r_strobe;
  logic                    r_adv;
  logic [CW-1:0]           r_clr_left;

  logic                    w_xfer;
  logic                    w_printable;
  logic [X_BITS-1:0]       w_adv_x;
  logic [Y_BITS-1:0]       w_adv_y;
  logic [Y_BITS-1:0]       w_nl_y;

  assign in_ready     = (r_state == S_IDLE) && !clear_start && !reset;
  assign busy         = (r_state != S_IDLE);
  assign w_xfer       = in_valid && in_ready;
  assign w_printable  = (in_data >= 8'h20) && (in_data <= 8'h7E);

  assign cursor_x     = r_cx;
  assign cursor_y     = r_cy;
  assign m_address    = r_addr;
  assign m_writedata  = r_data;
  assign m_chipselect = r_strobe;
  assign m_write      = r_strobe;
  assign m_byteenable = r_strobe;

  assign w_nl_y = (r_cy == LAST_Y) ? '0 : r_cy + ONE_Y;

  always_comb begin
    w_adv_x = r_cx + ONE_X;
    w_adv_y = r_cy;
    if (r_cx == LAST_X) begin
      w_adv_x = '0;
      w_adv_y = w_nl_y;
    end
  end

`ifdef CSW_BACKSPACE_EN
  logic [X_BITS-1:0] w_back_x;
  logic [Y_BITS-1:0] w_back_y;

  // Backspace at the top-left corner stays put and still blanks (0,0).
  always_comb begin
    w_back_x = r_cx;
    w_back_y = r_cy;
    if (r_cx != '0) begin
      w_back_x = r_cx - ONE_X;
    end else if (r_cy != '0) begin
      w_back_x = LAST_X;
      w_back_y = r_cy - ONE_Y;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_cx       <= '0;
      r_cy       <= '0;
      r_addr     <= '0;
      r_data     <= '0;
      r_strobe   <= 1'b0;
      r_adv      <= 1'b0;
      r_clr_left <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (clear_start) begin
            r_state    <= S_CLEAR;
            r_addr     <= '0;
            r_data     <= 8'h20;
            r_strobe   <= 1'b1;
            r_clr_left <= CLR_LAST;
          end else if (w_xfer) begin
            if (w_printable) begin
              r_state  <= S_WRITE;
              r_addr   <= {r_cy, r_cx};
              r_data   <= in_data;
              r_strobe <= 1'b1;
              r_adv    <= 1'b1;
            end else if (in_data == 8'h0A) begin
              r_cx <= '0;
              r_cy <= w_nl_y;
            end else if (in_data == 8'h0D) begin
              r_cx <= '0;
`ifdef CSW_BACKSPACE_EN
            end else if (in_data == 8'h08) begin
              r_cx     <= w_back_x;
              r_cy     <= w_back_y;
              r_addr   <= {w_back_y, w_back_x};
              r_data   <= 8'h20;
              r_strobe <= 1'b1;
              r_adv    <= 1'b0;
              r_state  <= S_WRITE;
`endif
            end
          end
        end
        S_WRITE: begin
          if (!m_waitrequest) begin
            r_state  <= S_IDLE;
            r_strobe <= 1'b0;
            if (r_adv) begin
              r_cx <= w_adv_x;
              r_cy <= w_adv_y;
            end
          end
        end
        S_CLEAR: begin
          // r_clr_left counts the writes still owed after the one on the bus.
          if (!m_waitrequest) begin
            if (r_clr_left == '0) begin
              r_state  <= S_IDLE;
              r_strobe <= 1'b0;
              r_cx     <= '0;
              r_cy     <= '0;
            end else begin
              r_clr_left <= r_clr_left - ONE_C;
              if (r_addr[X_BITS-1:0] == LAST_X) begin
                r_addr <= {r_addr[X_BITS+Y_BITS-1:X_BITS] + ONE_Y, {X_BITS{1'b0}}};
              end else begin
                r_addr[X_BITS-1:0] <= r_addr[X_BITS-1:0] + ONE_X;
              end
            end
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_strobe <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_char_stream_writer.sv
// Bench for char_stream_writer: directed vector table, corner sequences and a
// randomized run checked against a linear-position screen model.
module tb_char_stream_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int TOTAL = COLS * ROWS;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        clear_start;
  logic        busy;
  logic [6:0]  cursor_x;
  logic [5:0]  cursor_y;
  logic [12:0] m_address;
  logic        m_chipselect;
  logic        m_write;
  logic        m_byteenable;
  logic [7:0]  m_writedata;
  logic        m_waitrequest;

  char_stream_writer #(.COLS(COLS), .ROWS(ROWS), .X_BITS(7)) dut (
    .clk(clk), .reset(reset),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .clear_start(clear_start), .busy(busy),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .m_address(m_address), .m_chipselect(m_chipselect), .m_write(m_write),
    .m_byteenable(m_byteenable), .m_writedata(m_writedata),
    .m_waitrequest(m_waitrequest)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [12:0] addr;
    logic [7:0]  data;
  } wr_t;

  typedef struct {
    logic [7:0]  ch;
    int          nwait;
    int          exp_nwr;
    logic [12:0] exp_addr;
    logic [7:0]  exp_data;
    int          exp_x;
    int          exp_y;
  } vec_t;

  wr_t act_q[$];
  wr_t exp_q[$];
  wr_t mon_w;
  int  n_vec = 0;
  int  n_err = 0;
  int  pos   = 0;

  // Completed bus writes; a write pending while reset is high never completes.
  always @(posedge clk) begin
    if (!reset && m_chipselect && m_write && m_byteenable && !m_waitrequest) begin
      mon_w.addr = m_address;
      mon_w.data = m_writedata;
      act_q.push_back(mon_w);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_cursor(input string name, input int x, input int y);
    chk({name, "_x"}, 32'(cursor_x), x);
    chk({name, "_y"}, 32'(cursor_y), y);
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b1; in_data = 8'h52; clear_start = 1'b0; m_waitrequest = 1'b0;
    cyc();
    cyc();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_strobes", 32'({m_chipselect, m_write, m_byteenable}), 0);
    chk("rst_addr", 32'(m_address), 0);
    chk("rst_data", 32'(m_writedata), 0);
    chk_cursor("rst_cursor", 0, 0);
    in_valid = 1'b0; in_data = 8'h00;
    reset = 1'b0;
    act_q.delete();
    exp_q.delete();
    pos = 0;
  endtask

  // Offers one character from idle, then services the bus write (if any) with
  // m_waitrequest high for the first nwait strobe cycles.
  task automatic send_char(input logic [7:0] ch, input int nwait, output int nstrb, output logic stable);
    logic [12:0] a0;
    int guard;
    nstrb = 0; stable = 1'b1; guard = 0;
    in_data = ch; in_valid = 1'b1; m_waitrequest = 1'b0;
    #1;
    chk("in_ready_idle", 32'(in_ready), 1);
    cyc();
    in_valid = 1'b0; in_data = 8'h00;
    a0 = m_address;
    while (busy && guard < 50) begin
      if (m_chipselect && m_write && m_byteenable) nstrb++;
      if (m_address !== a0) stable = 1'b0;
      m_waitrequest = (nstrb <= nwait);
      cyc();
      guard++;
    end
    m_waitrequest = 1'b0;
    chk("write_done", 32'(busy), 0);
  endtask

  function automatic wr_t mk_wr(input int p, input logic [7:0] d);
    wr_t w;
    w.addr = {6'(p / COLS), 7'(p % COLS)};
    w.data = d;
    return w;
  endfunction

  function automatic void model_char(input logic [7:0] ch);
    if (ch >= 8'h20 && ch <= 8'h7E) begin
      exp_q.push_back(mk_wr(pos, ch));
      pos = (pos + 1) % TOTAL;
    end else if (ch == 8'h0A) begin
      pos = ((pos / COLS + 1) % ROWS) * COLS;
    end else if (ch == 8'h0D) begin
      pos = (pos / COLS) * COLS;
`ifdef CSW_BACKSPACE_EN
    end else if (ch == 8'h08) begin
      if (pos > 0) pos = pos - 1;
      exp_q.push_back(mk_wr(pos, 8'h20));
`endif
    end
  endfunction

  function automatic logic [7:0] pick_char();
    int r;
    r = $urandom_range(15, 0);
    case (r)
      0:       return 8'h0A;
      1:       return 8'h0D;
      2:       return 8'h08;
      3:       return 8'($urandom_range(255, 0));
      default: return 8'(8'h20 + $urandom_range(94, 0));
    endcase
  endfunction

  task automatic drain();
    wr_t a;
    wr_t e;
    while (act_q.size() > 0) begin
      a = act_q.pop_front();
      chk("wr_col_range", 32'(a.addr[6:0] < 7'(COLS)), 1);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL spurious_write: got addr 0x%0h data 0x%0h, expected no write", a.addr, a.data);
      end else begin
        e = exp_q.pop_front();
        chk("wr_addr", 32'(a.addr), 32'(e.addr));
        chk("wr_data", 32'(a.data), 32'(e.data));
      end
    end
  endtask

  initial begin
    vec_t tbl[11];
    int ns;
    logic st;
    int guard;
    int bad;
    int clears;
    logic exp_busy;
    logic [7:0] ch;

    reset = 1'b1; in_data = 8'h00; in_valid = 1'b0; clear_start = 1'b0; m_waitrequest = 1'b0;

    tbl[0]  = '{8'h41, 0, 1, 13'h0000, 8'h41, 1, 0};
    tbl[1]  = '{8'h42, 2, 1, 13'h0001, 8'h42, 2, 0};
    tbl[2]  = '{8'h0D, 0, 0, 13'h0000, 8'h00, 0, 0};
    tbl[3]  = '{8'h0A, 0, 0, 13'h0000, 8'h00, 0, 1};
    tbl[4]  = '{8'h1F, 0, 0, 13'h0000, 8'h00, 0, 1};
    tbl[5]  = '{8'h7F, 0, 0, 13'h0000, 8'h00, 0, 1};
    tbl[6]  = '{8'h20, 1, 1, 13'h0080, 8'h20, 1, 1};
    tbl[7]  = '{8'h7E, 0, 1, 13'h0081, 8'h7E, 2, 1};
    tbl[8]  = '{8'hC1, 0, 0, 13'h0000, 8'h00, 2, 1};
    tbl[9]  = '{8'h0A, 0, 0, 13'h0000, 8'h00, 0, 2};
    tbl[10] = '{8'h00, 0, 0, 13'h0000, 8'h00, 0, 2};

    do_reset();
    for (int i = 0; i < 11; i++) begin
      act_q.delete();
      send_char(tbl[i].ch, tbl[i].nwait, ns, st);
      chk("tbl_nwr", act_q.size(), tbl[i].exp_nwr);
      if (tbl[i].exp_nwr == 1 && act_q.size() > 0) begin
        chk("tbl_addr", 32'(act_q[0].addr), 32'(tbl[i].exp_addr));
        chk("tbl_data", 32'(act_q[0].data), 32'(tbl[i].exp_data));
      end
      if (tbl[i].nwait > 0) chk("tbl_strobe_cycles", ns, tbl[i].nwait + 1);
      chk_cursor("tbl_cursor", tbl[i].exp_x, tbl[i].exp_y);
    end

    // End-of-row write held off by three stall cycles.
    do_reset();
    for (int i = 0; i < 79; i++) send_char(8'h78, 0, ns, st);
    chk_cursor("eol_pre", 79, 0);
    act_q.delete();
    send_char(8'h5A, 3, ns, st);
    chk("eol_strobe_cycles", ns, 4);
    chk("eol_addr_stable", 32'(st), 1);
    chk("eol_nwr", act_q.size(), 1);
    if (act_q.size() > 0) begin
      chk("eol_addr", 32'(act_q[0].addr), 32'h004F);
      chk("eol_data", 32'(act_q[0].data), 32'h5A);
    end
    chk_cursor("eol_cursor", 0, 1);

    // Bottom-right wrap and newline wrap on the last row.
    do_reset();
    for (int i = 0; i < 59; i++) send_char(8'h0A, 0, ns, st);
    for (int i = 0; i < 79; i++) send_char(8'h61, 0, ns, st);
    chk_cursor("wrap_pre", 79, 59);
    act_q.delete();
    send_char(8'h51, 0, ns, st);
    chk("wrap_nwr", act_q.size(), 1);
    if (act_q.size() > 0) chk("wrap_addr", 32'(act_q[0].addr), 32'h1DCF);
    chk_cursor("wrap_cursor", 0, 0);
    for (int i = 0; i < 59; i++) send_char(8'h0A, 0, ns, st);
    for (int i = 0; i < 5; i++) send_char(8'h62, 0, ns, st);
    chk_cursor("lf_wrap_pre", 5, 59);
    act_q.delete();
    send_char(8'h0A, 0, ns, st);
    chk("lf_wrap_nwr", act_q.size(), 0);
    chk_cursor("lf_wrap_cursor", 0, 0);

    // Backspace from the start of row 3.
    do_reset();
    for (int i = 0; i < 3; i++) send_char(8'h0A, 0, ns, st);
    act_q.delete();
    send_char(8'h08, 0, ns, st);
`ifdef CSW_BACKSPACE_EN
    chk("bs_nwr", act_q.size(), 1);
    if (act_q.size() > 0) begin
      chk("bs_addr", 32'(act_q[0].addr), 32'h014F);
      chk("bs_data", 32'(act_q[0].data), 32'h20);
    end
    chk_cursor("bs_cursor", 79, 2);
`else
    chk("bs_nwr", act_q.size(), 0);
    chk_cursor("bs_cursor", 0, 3);
`endif

    // Full clear, requested together with a valid character; a second request mid-clear is ignored.
    do_reset();
    send_char(8'h41, 0, ns, st);
    act_q.delete();
    clear_start = 1'b1; in_valid = 1'b1; in_data = 8'h4B;
    #1;
    chk("clr_in_ready", 32'(in_ready), 0);
    cyc();
    clear_start = 1'b0;
    chk("clr_busy", 32'(busy), 1);
    guard = 0;
    while (busy && guard < 20000) begin
      m_waitrequest = ($urandom_range(3, 0) == 0);
      clear_start = (guard == 50);
      cyc();
      guard++;
    end
    in_valid = 1'b0; clear_start = 1'b0; m_waitrequest = 1'b0;
    chk("clr_busy_drop", 32'(busy), 0);
    chk("clr_count", act_q.size(), TOTAL);
    bad = 0;
    for (int i = 0; i < act_q.size(); i++) begin
      if (act_q[i].addr !== mk_wr(i, 8'h20).addr || act_q[i].data !== 8'h20) bad++;
    end
    chk("clr_order_errs", bad, 0);
    if (act_q.size() > 0) chk("clr_last_addr", 32'(act_q[act_q.size() - 1].addr), 32'h1DCF);
    chk_cursor("clr_cursor", 0, 0);
    chk("clr_strobes_idle", 32'({m_chipselect, m_write, m_byteenable}), 0);

    // Reset during the clear, after 100 completed writes.
    do_reset();
    send_char(8'h41, 0, ns, st);
    act_q.delete();
    clear_start = 1'b1;
    cyc();
    clear_start = 1'b0;
    guard = 0;
    while (act_q.size() < 100 && guard < 500) begin
      cyc();
      guard++;
    end
    chk("abort_pre_count", act_q.size(), 100);
    reset = 1'b1;
    cyc();
    chk("abort_strobes", 32'({m_chipselect, m_write, m_byteenable}), 0);
    chk("abort_busy", 32'(busy), 0);
    chk_cursor("abort_cursor", 0, 0);
    reset = 1'b0;
    cyc();
    chk("abort_count", act_q.size(), 100);
    chk("abort_idle", 32'(busy), 0);

    // Randomized traffic against the screen model.
    do_reset();
    clears = 0;
    for (int c = 0; c < 3000; c++) begin
      cyc();
      drain();
      exp_busy = (exp_q.size() != 0);
      chk("rnd_busy", 32'(busy), 32'(exp_busy));
      chk("rnd_strobes", 32'({m_chipselect, m_write, m_byteenable}), exp_busy ? 32'h7 : 32'h0);
      if (!exp_busy) chk_cursor("rnd_cursor", pos % COLS, pos / COLS);
      ch = pick_char();
      m_waitrequest = ($urandom_range(3, 0) == 0);
      in_valid = ($urandom_range(1, 0) == 1);
      in_data = ch;
      clear_start = (clears < 2) && ($urandom_range(699, 0) == 0);
      #1;
      chk("rnd_in_ready", 32'(in_ready), 32'(!exp_busy && !clear_start));
      if (clear_start && !exp_busy) begin
        for (int p = 0; p < TOTAL; p++) exp_q.push_back(mk_wr(p, 8'h20));
        pos = 0;
        clears++;
      end else if (in_valid && !exp_busy && !clear_start) begin
        model_char(ch);
      end
    end
    in_valid = 1'b0; clear_start = 1'b0; m_waitrequest = 1'b0;
    guard = 0;
    while ((exp_q.size() > 0 || act_q.size() > 0) && guard < 10000) begin
      cyc();
      drain();
      guard++;
    end
    chk("rnd_pending_left", exp_q.size(), 0);
    chk("rnd_final_busy", 32'(busy), 0);
    chk_cursor("rnd_final_cursor", pos % COLS, pos / COLS);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/char_stream_writer.md
CHAR_STREAM_WRITER -- requirements
Module: char_stream_writer

Interface
REQ-001 SHALL provide parameter COLS, default 80, characters per row.
REQ-002 SHALL provide parameter ROWS, default 60, rows per screen.
REQ-003 SHALL provide parameter X_BITS, default 7, column field width of the buffer address.
REQ-004 SHALL provide port clk  input  1  single clock for all logic.
REQ-005 SHALL provide port reset  input  1  reset, synchronous to clk, active-high.
REQ-006 SHALL provide port in_data  input  8  ASCII character from upstream stream.
REQ-007 SHALL provide port in_valid  input  1  in_data valid.
REQ-008 SHALL provide port in_ready  output  1  block accepts in_data this cycle.
REQ-009 SHALL provide port clear_start  input  1  one-cycle request to blank the screen.
REQ-010 SHALL provide port busy  output  1  write or clear in progress.
REQ-011 SHALL provide port cursor_x  output  7  current column.
REQ-012 SHALL provide port cursor_y  output  6  current row.
REQ-013 SHALL provide port m_address  output  13  char buffer address, {row[5:0], col[6:0]}.
REQ-014 SHALL provide port m_chipselect, m_write, m_byteenable  output  1 each  Avalon-MM write strobes to char buffer slave.
REQ-015 SHALL provide port m_writedata  output  8  character written.
REQ-016 SHALL provide port m_waitrequest  input  1  slave stall.

Function
REQ-017 SHALL implement states IDLE, WRITE, CLEAR; busy = (state != IDLE).
REQ-018 in_ready SHALL be 1 only in IDLE with clear_start low; transfer occurs when in_valid & in_ready.
REQ-019 Printable char (0x20-0x7E) accepted SHALL move to WRITE with m_address={cursor_y,cursor_x}, m_writedata=char, registered (output one cycle after transfer).
REQ-020 In WRITE, m_chipselect=m_write=m_byteenable=1 with address/data stable until the cycle m_waitrequest=0; that cycle completes the write, next state IDLE.
REQ-021 On write completion cursor SHALL advance: x+1; x==COLS-1 -> x=0, y+1; y==ROWS-1 with wrap -> y=0.
REQ-022 0x0A SHALL set x=0, y=y+1 (wrap at ROWS-1 to 0), no bus write, stay IDLE.
REQ-023 0x0D SHALL set x=0, no bus write, stay IDLE.
REQ-024 All other codes SHALL be consumed and discarded, cursor unchanged.
REQ-025 clear_start in IDLE SHALL enter CLEAR; clear_start and in_valid same cycle: clear wins, char not accepted.
REQ-026 CLEAR SHALL write 0x20 to all COLS*ROWS positions in row-major order from (0,0), one write per non-stalled cycle, honouring m_waitrequest per REQ-020.
REQ-027 After last clear write completes SHALL return to IDLE with cursor (0,0).
REQ-028 clear_start while busy SHALL be ignored.
REQ-029 Outside WRITE/CLEAR, m_chipselect, m_write, m_byteenable SHALL be 0.
REQ-030 Addresses with column >= COLS SHALL never be issued.

Reset
REQ-031 On reset: state IDLE, cursor (0,0), m_* strobes 0, m_address 0, m_writedata 0, busy 0, in_ready 0 during reset cycle.
REQ-032 Reset mid-WRITE or mid-CLEAR SHALL abort immediately; strobes 0 next cycle, no completion of the pending write.

Configuration
REQ-033 With CSW_BACKSPACE_EN defined, 0x08 SHALL move cursor back one position (x==0 -> x=COLS-1, y-1; at (0,0) stay), then write 0x20 there without advancing.
REQ-034 Without CSW_BACKSPACE_EN, 0x08 SHALL be discarded per REQ-024.

Verification
REQ-035 Reset, send 'A' (0x41), waitrequest 0 -> one write addr 0x0000 data 0x41, cursor (1,0).
REQ-036 Cursor (79,0), send 'Z', waitrequest high 3 cycles -> strobes held 4 cycles, addr 0x004F stable, then cursor (0,1).
REQ-037 Cursor (79,59), send 'Q' -> write addr {59,79}=0x1DCF, cursor wraps (0,0); 0x0A at (5,59) -> (0,0), no write.
REQ-038 Pulse clear_start with in_valid=1 -> in_ready 0, exactly 4800 writes of 0x20, last addr 0x1DCF, busy drops, cursor (0,0).
REQ-039 Assert reset at clear write 100 -> strobes 0 next cycle, state IDLE, cursor (0,0).
REQ-040 CSW_BACKSPACE_EN: cursor (0,3), send 0x08 -> write 0x20 at {2,79}=0x014F, cursor (79,2); undefined -> no write, cursor unchanged.
